// File: rtl/vector_commit_tracker_pkg.sv
// Shared types and sizing for the vector commit tracker: issue numbers,
// wrap-aware pointers, per-lane issue numbers and the tracker entry layout.
package vector_commit_tracker_pkg;

  localparam int NUM_LANE    = 4;
  localparam int NUM_ENTRY   = 8;
  localparam int WIDTH_ISSUE = 3;
  localparam int IDX_W       = $clog2(NUM_ENTRY);
  localparam int PTR_W       = IDX_W + 1;

  typedef logic [WIDTH_ISSUE-1:0] issue_no_t;
  typedef logic [PTR_W-1:0]       commit_ptr_t;
  typedef logic [IDX_W-1:0]       entry_idx_t;
  typedef logic [NUM_LANE-1:0]    lane_mask_t;
  typedef issue_no_t [NUM_LANE-1:0] lane_no_t;

  typedef struct packed {
    logic       v;
    issue_no_t  issue_no;
    logic       commit;
    lane_mask_t en_lane;
    lane_mask_t en_commit;
  } commit_tab_v;

  // An entry is complete once every participating lane has reported.
  function automatic logic entry_complete(commit_tab_v e);
    return e.v & (&(e.en_commit | ~e.en_lane));
  endfunction

endpackage

// File: rtl/vector_commit_tracker_if.sv
// Issue, lane-commit and retire signals between the scalar unit and the
// commit tracker.
interface vector_commit_tracker_if;
  import vector_commit_tracker_pkg::*;

  logic        i_issue_req;
  issue_no_t   i_issue_no;
  lane_mask_t  i_en_lane;
  logic        o_issue_rdy;
  lane_mask_t  i_lane_commit;
  lane_no_t    i_lane_no;
  logic        o_commit;
  issue_no_t   o_commit_no;
  logic        o_empty;
  commit_ptr_t o_count;
  logic        o_err;

  modport master (
    output i_issue_req, i_issue_no, i_en_lane, i_lane_commit, i_lane_no,
    input  o_issue_rdy, o_commit, o_commit_no, o_empty, o_count, o_err
  );

  modport slave (
    input  i_issue_req, i_issue_no, i_en_lane, i_lane_commit, i_lane_no,
    output o_issue_rdy, o_commit, o_commit_no, o_empty, o_count, o_err
  );

endinterface

// File: rtl/vector_commit_tracker_oldest_match.sv
// Picks the matching entry closest to the read pointer, walking the ring
// from the head towards the tail.
module vector_commit_tracker_oldest_match
  import vector_commit_tracker_pkg::*;
(
  input  logic [NUM_ENTRY-1:0] i_match,
  input  entry_idx_t           i_rd_idx,
  output logic                 o_found,
  output entry_idx_t           o_idx
);

  // Scan youngest-to-oldest so the last hit written is the oldest one.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (i_match[i_rd_idx + entry_idx_t'(i)]) begin
        o_found = 1'b1;
        o_idx   = i_rd_idx + entry_idx_t'(i);
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/vector_commit_tracker.sv
// In-order commit scheduler: one entry per issued vector command, per-lane
// commit collection and in-order retire of completed entries.
module vector_commit_tracker
  import vector_commit_tracker_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  vector_commit_tracker_if.slave  bus
);

  commit_tab_v tab_q [NUM_ENTRY];
  commit_tab_v tab_d [NUM_ENTRY];
  commit_ptr_t rd_ptr_q, rd_ptr_d;
  commit_ptr_t wr_ptr_q, wr_ptr_d;
  logic        commit_q, commit_d;
  issue_no_t   commit_no_q, commit_no_d;
  logic        err_q, err_d;

  commit_ptr_t          count;
  logic                 full;
  entry_idx_t           rd_idx;
  entry_idx_t           wr_idx;
  logic                 issue_acc;
  logic                 head_done;
  logic [NUM_ENTRY-1:0] lane_match [NUM_LANE];
  lane_mask_t           lane_found;
  entry_idx_t           lane_idx [NUM_LANE];

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == commit_ptr_t'(NUM_ENTRY));
  assign rd_idx    = rd_ptr_q[IDX_W-1:0];
  assign wr_idx    = wr_ptr_q[IDX_W-1:0];
  assign issue_acc = bus.i_issue_req & ~full;
  assign head_done = entry_complete(tab_q[rd_idx]);

  // Candidate entries per lane, from start-of-cycle state only.
  always_comb begin
    for (int k = 0; k < NUM_LANE; k++) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        lane_match[k][e] = tab_q[e].v & tab_q[e].en_lane[k] &
                           (tab_q[e].issue_no == bus.i_lane_no[k]);
      end
    end
  end

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    vector_commit_tracker_oldest_match u_oldest_match (
      .i_match  (lane_match[k]),
      .i_rd_idx (rd_idx),
      .o_found  (lane_found[k]),
      .o_idx    (lane_idx[k])
    );
  end

  // Apply lane commits, retire and issue together; their slots never collide.
  always_comb begin
    tab_d = tab_q;
    for (int k = 0; k < NUM_LANE; k++) begin
      if (bus.i_lane_commit[k] && lane_found[k]) begin
        tab_d[lane_idx[k]].en_commit[k] = 1'b1;
      end else begin
        tab_d[lane_idx[k]].en_commit[k] = tab_d[lane_idx[k]].en_commit[k];
      end
    end
    if (head_done) begin
      tab_d[rd_idx] = '0;
    end else begin
      tab_d[rd_idx] = tab_d[rd_idx];
    end
    if (issue_acc) begin
      tab_d[wr_idx] = '{v: 1'b1, issue_no: bus.i_issue_no, commit: 1'b0,
                        en_lane: bus.i_en_lane, en_commit: '0};
    end else begin
      tab_d[wr_idx] = tab_d[wr_idx];
    end
    rd_ptr_d    = rd_ptr_q + commit_ptr_t'(head_done);
    wr_ptr_d    = wr_ptr_q + commit_ptr_t'(issue_acc);
    commit_d    = head_done;
    commit_no_d = head_done ? tab_q[rd_idx].issue_no : commit_no_q;
    err_d       = err_q | (bus.i_issue_req & full) |
                  (|(bus.i_lane_commit & ~lane_found));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        tab_q[e] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      commit_q    <= 1'b0;
      commit_no_q <= '0;
      err_q       <= 1'b0;
    end else begin
      tab_q       <= tab_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      commit_q    <= commit_d;
      commit_no_q <= commit_no_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_issue_rdy = ~full;
  assign bus.o_commit    = commit_q;
  assign bus.o_commit_no = commit_no_q;
  assign bus.o_empty     = (count == '0);
  assign bus.o_count     = count;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_vector_commit_tracker.sv
// Directed bench for the commit tracker: a queue-based reference model is
// compared against the outputs every cycle, plus literal spot checks.
module tb_vector_commit_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  vector_commit_tracker_if bus ();

  vector_commit_tracker dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] no;
    logic [3:0] en;
    logic [3:0] got;
  } m_ent_t;

  m_ent_t     mq[$];
  logic       m_commit = 1'b0;
  logic [2:0] m_commit_no = 3'd0;
  logic       m_err = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] all_lanes(input logic [2:0] n);
    return {4{n}};
  endfunction

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic model_update();
    logic       retire;
    logic       found;
    logic [2:0] lno;
    if (rst) begin
      mq.delete();
      m_commit    = 1'b0;
      m_commit_no = 3'd0;
      m_err       = 1'b0;
      return;
    end
    retire = (mq.size() > 0) && ((mq[0].got | ~mq[0].en) == 4'hF);
    for (int k = 0; k < 4; k++) begin
      if (bus.i_lane_commit[k]) begin
        found = 1'b0;
        lno = bus.i_lane_no[k];
        for (int j = 0; j < mq.size(); j++) begin
          if (!found && mq[j].no == lno && mq[j].en[k]) begin
            mq[j].got[k] = 1'b1;
            found = 1'b1;
          end
        end
        if (!found) m_err = 1'b1;
      end
    end
    if (bus.i_issue_req) begin
      if (mq.size() < 8) mq.push_back('{no: bus.i_issue_no, en: bus.i_en_lane, got: 4'h0});
      else m_err = 1'b1;
    end
    if (retire) begin
      m_commit    = 1'b1;
      m_commit_no = mq[0].no;
      void'(mq.pop_front());
    end else begin
      m_commit = 1'b0;
    end
  endtask

  task automatic cyc(input logic req, input logic [2:0] no, input logic [3:0] en,
                     input logic [3:0] lc, input logic [11:0] lnos);
    bus.i_issue_req   = req;
    bus.i_issue_no    = no;
    bus.i_en_lane     = en;
    bus.i_lane_commit = lc;
    bus.i_lane_no     = lnos;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 4'h0, 4'h0, 12'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("commit", int'(bus.o_commit), int'(m_commit));
      chk("commit_no", int'(bus.o_commit_no), int'(m_commit_no));
      chk("count", int'(bus.o_count), mq.size());
      chk("empty", int'(bus.o_empty), int'(mq.size() == 0));
      chk("issue_rdy", int'(bus.o_issue_rdy), int'(mq.size() != 8));
      chk("err", int'(bus.o_err), int'(m_err));
    end
  end

  initial begin
    bus.i_issue_req   = 1'b0;
    bus.i_issue_no    = 3'd0;
    bus.i_en_lane     = 4'h0;
    bus.i_lane_commit = 4'h0;
    bus.i_lane_no     = 12'h0;
    do_reset();
    idle();
    chk_en = 1'b1;

    // reset state
    chk("rst_empty", int'(bus.o_empty), 1);
    chk("rst_count", int'(bus.o_count), 0);
    chk("rst_rdy", int'(bus.o_issue_rdy), 1);
    chk("rst_commit", int'(bus.o_commit), 0);
    chk("rst_err", int'(bus.o_err), 0);

    // two-lane command, commits spread out
    cyc(1'b1, 3'd3, 4'b0101, 4'h0, 12'h0);
    chk("t2_count1", int'(bus.o_count), 1);
    cyc(1'b0, 3'd0, 4'h0, 4'b0001, all_lanes(3'd3));
    idle();
    cyc(1'b0, 3'd0, 4'h0, 4'b0100, all_lanes(3'd3));
    chk("t2_no_early", int'(bus.o_commit), 0);
    idle();
    chk("t2_commit", int'(bus.o_commit), 1);
    chk("t2_commit_no", int'(bus.o_commit_no), 3);
    chk("t2_count0", int'(bus.o_count), 0);
    idle();
    chk("t2_pulse_end", int'(bus.o_commit), 0);

    // younger complete entry waits behind head
    cyc(1'b1, 3'd1, 4'b1111, 4'h0, 12'h0);
    cyc(1'b1, 3'd2, 4'b0001, 4'h0, 12'h0);
    cyc(1'b0, 3'd0, 4'h0, 4'b0001, all_lanes(3'd2));
    idle();
    chk("t3_wait", int'(bus.o_commit), 0);
    cyc(1'b0, 3'd0, 4'h0, 4'b1111, all_lanes(3'd1));
    idle();
    chk("t3_first_no", int'(bus.o_commit_no), 1);
    idle();
    chk("t3_second", int'(bus.o_commit), 1);
    chk("t3_second_no", int'(bus.o_commit_no), 2);
    idle();

    // fill, overflow, drain and wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 4'b0001, 4'h0, 12'h0);
    chk("t4_full_rdy", int'(bus.o_issue_rdy), 0);
    cyc(1'b1, 3'd0, 4'b0001, 4'h0, 12'h0);
    chk("t4_ovf_err", int'(bus.o_err), 1);
    chk("t4_ovf_count", int'(bus.o_count), 8);
    for (int i = 0; i < 8; i++) cyc(1'b0, 3'd0, 4'h0, 4'b0001, all_lanes(3'(i)));
    idle();
    idle();
    chk("t4_drained", int'(bus.o_empty), 1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 4'b0010, 4'h0, 12'h0);
    chk("t4_refill", int'(bus.o_count), 8);

    // commit to an entry allocated in the same cycle is an error
    do_reset();
    cyc(1'b1, 3'd5, 4'b0010, 4'b0010, all_lanes(3'd5));
    chk("t5a_err", int'(bus.o_err), 1);
    chk("t5a_count", int'(bus.o_count), 1);

    // unmatched lane commit
    do_reset();
    cyc(1'b1, 3'd4, 4'b0010, 4'h0, 12'h0);
    cyc(1'b0, 3'd0, 4'h0, 4'b0010, all_lanes(3'd5));
    chk("t5_err", int'(bus.o_err), 1);
    chk("t5_count", int'(bus.o_count), 1);
    cyc(1'b0, 3'd0, 4'h0, 4'b0010, all_lanes(3'd4));
    idle();
    chk("t5_retire_no", int'(bus.o_commit_no), 4);

    // no-lane command waits behind head, then reset mid-flow
    do_reset();
    cyc(1'b1, 3'd7, 4'b0001, 4'h0, 12'h0);
    cyc(1'b1, 3'd6, 4'b0000, 4'h0, 12'h0);
    idle();
    chk("t6_wait_count", int'(bus.o_count), 2);
    cyc(1'b0, 3'd0, 4'h0, 4'b0001, all_lanes(3'd7));
    idle();
    chk("t6_first_no", int'(bus.o_commit_no), 7);
    idle();
    chk("t6_zero_en", int'(bus.o_commit), 1);
    chk("t6_zero_en_no", int'(bus.o_commit_no), 6);
    for (int i = 1; i < 4; i++) cyc(1'b1, 3'(i), 4'b1111, 4'h0, 12'h0);
    chk("t6_pre_rst", int'(bus.o_count), 3);
    do_reset();
    chk("t6_rst_count", int'(bus.o_count), 0);
    chk("t6_rst_commit", int'(bus.o_commit), 0);
    idle();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
